// File: rtl/contador_mod_n.sv
// contador_mod_n -- parametrised modulo-N timing-unit counter.
//
// Counts 0..MODULO-1 up or down, with enable, synchronous clear, parallel
// load (clamped into range), free-run wrap or one-shot stop, a one-cycle
// terminal-count pulse and a sticky completion flag.
//
// Ports:
//   CLK       in   1      system clock, rising edge
//   RST_N     in   1      asynchronous reset, active-low
//   en        in   1      count enable, one step per cycle
//   clr       in   1      synchronous clear (highest priority)
//   load      in   1      synchronous parallel load
//   load_val  in   WIDTH  value to load, clamped to MODULO-1
//   up_dn     in   1      1 = count up, 0 = count down
//   one_shot  in   1      1 = stop at terminal value, 0 = wrap
//   salida    out  WIDTH  current count (registered)
//   tc        out  1      terminal-count pulse (registered, one cycle)
//   done      out  1      sticky one-shot completion flag (registered)
module contador_mod_n #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             one_shot,
  output logic [WIDTH-1:0] salida,
  output logic             tc,
  output logic             done
);

  generate
    if (WIDTH < 2 || MODULO < 2 || longint'(MODULO) > (64'd1 << WIDTH)) begin : g_bad_params
      $error("contador_mod_n: need WIDTH >= 2 and 2 <= MODULO <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q,  tc_d;
  logic             done_q, done_d;
  logic             at_term;

  // Loaded values outside the count range would break the "never >= MODULO"
  // invariant, so they are pinned to the top of the range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if ({1'b0, v} >= (WIDTH+1)'(MODULO)) return MAX_VAL;
    return v;
  endfunction

  // Terminal value follows the direction requested this very cycle.
  assign at_term = up_dn ? (cnt_q == MAX_VAL) : (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    done_d = done_q;
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (load) begin
      cnt_d  = clamp_load(load_val);
      done_d = 1'b0;
    end else if (en && !done_q) begin
      if (at_term) begin
        tc_d = 1'b1;
        if (one_shot) begin
          done_d = 1'b1;                       // hold at terminal value
        end else begin
          cnt_d = up_dn ? '0 : MAX_VAL;        // explicit wrap for any MODULO
        end
      end else begin
        cnt_d = up_dn ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      done_q <= done_d;
    end
  end

  assign salida = cnt_q;
  assign tc     = tc_q;
  assign done   = done_q;

endmodule

// File: tb/tb_contador_mod_n.sv
module tb_contador_mod_n;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       en, clr, load, up_dn, one_shot;
  logic [3:0] load_val;
  logic [3:0] salida;
  logic       tc, done;

  int checks = 0;
  int errors = 0;

  contador_mod_n #(.WIDTH(4), .MODULO(10)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .up_dn    (up_dn),
    .one_shot (one_shot),
    .salida   (salida),
    .tc       (tc),
    .done     (done)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; en = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    up_dn = 1'b1; one_shot = 1'b0;
    tick; tick;
    checks++;
    if ({salida, tc, done} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: salida=%0d tc=%b done=%b, expected 0 0 0", salida, tc, done);
    end
  endtask

  task automatic test_count_up;
    logic [3:0] exp_v [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    RST_N = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick;
      checks++;
      if ({salida, tc, done} !== {exp_v[k], (k == 9), 1'b0}) begin
        errors++;
        $display("FAIL count_up[%0d]: salida=%0d tc=%b done=%b, expected %0d %b 0",
                 k, salida, tc, done, exp_v[k], (k == 9));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap;
    logic [3:0] exp_v [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    load = 1'b1; load_val = 4'd2;
    tick;
    checks++;
    if ({salida, tc} !== {4'd2, 1'b0}) begin
      errors++;
      $display("FAIL down_load: salida=%0d tc=%b, expected 2 0", salida, tc);
    end
    load = 1'b0; up_dn = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if ({salida, tc, done} !== {exp_v[k], (k == 2), 1'b0}) begin
        errors++;
        $display("FAIL down_wrap[%0d]: salida=%0d tc=%b done=%b, expected %0d %b 0",
                 k, salida, tc, done, exp_v[k], (k == 2));
      end
    end
    en = 1'b0; up_dn = 1'b1;
  endtask

  task automatic test_one_shot;
    logic [3:0] exp_v  [5] = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    logic       exp_tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_dn [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    load = 1'b1; load_val = 4'd7; one_shot = 1'b1;
    tick;
    checks++;
    if ({salida, done} !== {4'd7, 1'b0}) begin
      errors++;
      $display("FAIL oneshot_load: salida=%0d done=%b, expected 7 0", salida, done);
    end
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++;
      if ({salida, tc, done} !== {exp_v[k], exp_tc[k], exp_dn[k]}) begin
        errors++;
        $display("FAIL oneshot[%0d]: salida=%0d tc=%b done=%b, expected %0d %b %b",
                 k, salida, tc, done, exp_v[k], exp_tc[k], exp_dn[k]);
      end
    end
    // Leaving one-shot mode while done is set must not release the counter.
    one_shot = 1'b0;
    tick; tick;
    checks++;
    if ({salida, tc, done} !== {4'd9, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL oneshot_sticky: salida=%0d tc=%b done=%b, expected 9 0 1", salida, tc, done);
    end
    clr = 1'b1;
    tick;
    checks++;
    if ({salida, tc, done} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL oneshot_clr: salida=%0d tc=%b done=%b, expected 0 0 0", salida, tc, done);
    end
    clr = 1'b0; en = 1'b0;
  endtask

  task automatic test_priority_clamp;
    load = 1'b1; load_val = 4'd3;
    tick;
    clr = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1;
    tick;
    checks++;
    if ({salida, tc} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL prio_clr: salida=%0d tc=%b, expected 0 0", salida, tc);
    end
    clr = 1'b0; load_val = 4'd15;
    tick;
    checks++;
    if ({salida, tc} !== {4'd9, 1'b0}) begin
      errors++;
      $display("FAIL clamp: salida=%0d tc=%b, expected 9 0", salida, tc);
    end
    load = 1'b0;
    tick;
    checks++;
    if ({salida, tc, done} !== {4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL clamp_wrap: salida=%0d tc=%b done=%b, expected 0 1 0", salida, tc, done);
    end
    en = 1'b0;
  endtask

  task automatic test_enable_gating;
    logic [3:0] exp_v [6] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
    clr = 1'b1;
    tick;
    clr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      en = k[0];
      tick;
      checks++;
      if ({salida, tc} !== {exp_v[k], 1'b0}) begin
        errors++;
        $display("FAIL en_gate[%0d]: salida=%0d tc=%b, expected %0d 0", k, salida, tc, exp_v[k]);
      end
    end
    en = 1'b0; load = 1'b1; load_val = 4'd9;
    tick;
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if ({salida, tc} !== {4'd9, 1'b0}) begin
        errors++;
        $display("FAIL en_low_term[%0d]: salida=%0d tc=%b, expected 9 0", k, salida, tc);
      end
    end
    en = 1'b1;
    tick;
    checks++;
    if ({salida, tc} !== {4'd0, 1'b1}) begin
      errors++;
      $display("FAIL en_resume_tc: salida=%0d tc=%b, expected 0 1", salida, tc);
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset;
    // Mid free-running count at 6.
    load = 1'b1; load_val = 4'd5; one_shot = 1'b0;
    tick;
    load = 1'b0; en = 1'b1;
    tick;
    checks++;
    if (salida !== 4'd6) begin
      errors++;
      $display("FAIL async_pre: salida=%0d, expected 6", salida);
    end
    #3 RST_N = 1'b0;
    #1;
    checks++;
    if ({salida, tc, done} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_count: salida=%0d tc=%b done=%b, expected 0 0 0", salida, tc, done);
    end
    tick;
    RST_N = 1'b1;
    tick;
    checks++;
    if ({salida, tc, done} !== {4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_resume: salida=%0d tc=%b done=%b, expected 1 0 0", salida, tc, done);
    end
    // Reset while done is set and tc is pulsing.
    en = 1'b0; load = 1'b1; load_val = 4'd9; one_shot = 1'b1;
    tick;
    load = 1'b0; en = 1'b1;
    tick;
    checks++;
    if ({salida, tc, done} !== {4'd9, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL async_pre_done: salida=%0d tc=%b done=%b, expected 9 1 1", salida, tc, done);
    end
    #3 RST_N = 1'b0;
    #1;
    checks++;
    if ({salida, tc, done} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_done: salida=%0d tc=%b done=%b, expected 0 0 0", salida, tc, done);
    end
    one_shot = 1'b0;
    tick;
    RST_N = 1'b1;
    tick; tick;
    checks++;
    if ({salida, tc, done} !== {4'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_resume2: salida=%0d tc=%b done=%b, expected 2 0 0", salida, tc, done);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_down_wrap;
    test_one_shot;
    test_priority_clamp;
    test_enable_gating;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
